// File: rtl/register_file_pkg.sv
// Shared datapath constants for the CPU register file and its busy scoreboard.
package register_file_pkg;
  localparam int DATA_BUS_WIDTH     = 16;
  localparam int REGFILE_NUM_REGS   = 16;
  localparam int REGFILE_ADDR_WIDTH = $clog2(REGFILE_NUM_REGS);
endpackage

// File: rtl/register_file_scoreboard.sv
// Per-register busy bits: set by issue, cleared by writeback, issue wins on a tie.
// Updates on the clock edge; no backpressure, every set/clear is accepted.
module reg_scoreboard #(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr_en,
  input  logic [ADDR_WIDTH-1:0] i_clr_addr,
  input  logic                  i_set_en,
  input  logic [ADDR_WIDTH-1:0] i_set_addr,
  output logic [NUM_REGS-1:0]   o_busy
);
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Set applied after clear so a new writer supersedes the completing one.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign o_busy = r_busy;
endmodule

// File: rtl/register_file.sv
// Register file with 2 async read ports, 1 sync write port, write bypass and busy tracking.
// Write visible to readers same cycle (bypass) or next cycle; no backpressure.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BUS_WIDTH,
  parameter int NUM_REGS   = REGFILE_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ra_addr,
  output logic [DATA_WIDTH-1:0] ra_data,
  output logic                  ra_busy,
  input  logic [ADDR_WIDTH-1:0] rb_addr,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic                  rb_busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  output logic [NUM_REGS-1:0]   busy_vec
);
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  w_wr_live;
  logic                  w_iss_live;
  logic                  w_ra_hit;
  logic                  w_rb_hit;
  logic [NUM_REGS-1:0]   w_busy;

  // Gated by rst so nothing, including the bypass path, leaks through during reset.
  assign w_wr_live  = wr_en && !rst && !((ZERO_REG != 0) && (wr_addr == '0));
  assign w_iss_live = issue_en && !rst && !((ZERO_REG != 0) && (issue_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_live) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  reg_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_clr_en  (w_wr_live),
    .i_clr_addr(wr_addr),
    .i_set_en  (w_iss_live),
    .i_set_addr(issue_addr),
    .o_busy    (w_busy)
  );

  assign w_ra_hit = (BYPASS != 0) && w_wr_live && (wr_addr == ra_addr);
  assign w_rb_hit = (BYPASS != 0) && w_wr_live && (wr_addr == rb_addr);

  always_comb begin
    ra_data = w_ra_hit ? wr_data : r_regs[ra_addr];
    rb_data = w_rb_hit ? wr_data : r_regs[rb_addr];
    if ((ZERO_REG != 0) && (ra_addr == '0)) ra_data = '0;
    if ((ZERO_REG != 0) && (rb_addr == '0)) rb_data = '0;
    ra_busy = w_ra_hit ? 1'b0 : w_busy[ra_addr];
    rb_busy = w_rb_hit ? 1'b0 : w_busy[rb_addr];
  end

  assign busy_vec = w_busy;
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a BYPASS=1 and a BYPASS=0 instance driven by shared stimulus.
module tb_register_file;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ra_addr, rb_addr, wr_addr, issue_addr;
  logic        wr_en, issue_en;
  logic [15:0] wr_data;

  logic [15:0] a_ra, a_rb, a_bv, n_ra, n_rb, n_bv;
  logic        a_rab, a_rbb, n_rab, n_rbb;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  register_file #(.BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst),
    .ra_addr(ra_addr), .ra_data(a_ra), .ra_busy(a_rab),
    .rb_addr(rb_addr), .rb_data(a_rb), .rb_busy(a_rbb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .busy_vec(a_bv)
  );

  register_file #(.BYPASS(0)) dut_nob (
    .clk(clk), .rst(rst),
    .ra_addr(ra_addr), .ra_data(n_ra), .ra_busy(n_rab),
    .rb_addr(rb_addr), .rb_data(n_rb), .rb_busy(n_rbb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .busy_vec(n_bv)
  );

  typedef struct {
    logic [3:0]  ra, rb;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        ie;
    logic [3:0]  ia;
    logic [15:0] e_ra, e_rb;
    logic        e_rab, e_rbb;
    logic [15:0] e_bv;
  } vec_t;

  typedef struct {
    logic [15:0] a_ra, a_rb, a_bv, n_ra, n_rb, n_bv;
    logic        a_rab, a_rbb, n_rab, n_rbb;
  } exp_t;

  vec_t        tbl [16];
  exp_t        exp_q [$];
  logic [15:0] m_regs [16];
  logic [15:0] m_busy;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] ra, input logic [3:0] rb,
                              input logic we, input logic [3:0] wa, input logic [15:0] wd,
                              input logic ie, input logic [3:0] ia,
                              input logic [15:0] e_ra, input logic [15:0] e_rb,
                              input logic e_rab, input logic e_rbb, input logic [15:0] e_bv);
    vec_t v;
    v.ra = ra; v.rb = rb; v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
    v.e_ra = e_ra; v.e_rb = e_rb; v.e_rab = e_rab; v.e_rbb = e_rbb; v.e_bv = e_bv;
    return v;
  endfunction

  initial begin
    exp_t e;
    exp_t g;
    //            ra  rb  we wa  wd       ie ia   e_ra     e_rb     rab rbb e_bv (bypass build, pre-edge)
    tbl[0]  = mk(3,  5,  0, 0, 16'h0000, 0, 0,  16'h0000, 16'h0000, 0, 0, 16'h0000);
    tbl[1]  = mk(5,  5,  1, 5, 16'h1234, 0, 0,  16'h1234, 16'h1234, 0, 0, 16'h0000);
    tbl[2]  = mk(5,  5,  0, 0, 16'h0000, 0, 0,  16'h1234, 16'h1234, 0, 0, 16'h0000);
    tbl[3]  = mk(0,  0,  1, 0, 16'hFFFF, 1, 0,  16'h0000, 16'h0000, 0, 0, 16'h0000);
    tbl[4]  = mk(0,  5,  0, 0, 16'h0000, 0, 0,  16'h0000, 16'h1234, 0, 0, 16'h0000);
    tbl[5]  = mk(7,  7,  0, 0, 16'h0000, 1, 7,  16'h0000, 16'h0000, 0, 0, 16'h0000);
    tbl[6]  = mk(7,  3,  0, 0, 16'h0000, 0, 0,  16'h0000, 16'h0000, 1, 0, 16'h0080);
    tbl[7]  = mk(7,  3,  0, 0, 16'h0000, 0, 0,  16'h0000, 16'h0000, 1, 0, 16'h0080);
    tbl[8]  = mk(7,  7,  1, 7, 16'h0042, 0, 0,  16'h0042, 16'h0042, 0, 0, 16'h0080);
    tbl[9]  = mk(7,  2,  0, 0, 16'h0000, 0, 0,  16'h0042, 16'h0000, 0, 0, 16'h0000);
    tbl[10] = mk(2,  7,  1, 2, 16'hBEEF, 1, 2,  16'hBEEF, 16'h0042, 0, 0, 16'h0000);
    tbl[11] = mk(2,  2,  0, 0, 16'h0000, 0, 0,  16'hBEEF, 16'hBEEF, 1, 1, 16'h0004);
    tbl[12] = mk(9,  2,  1, 9, 16'h0077, 0, 0,  16'h0077, 16'hBEEF, 0, 1, 16'h0004);
    tbl[13] = mk(9,  9,  0, 0, 16'h0000, 0, 0,  16'h0077, 16'h0077, 0, 0, 16'h0004);
    tbl[14] = mk(9,  3,  1, 9, 16'h0099, 1, 3,  16'h0099, 16'h0000, 0, 0, 16'h0004);
    tbl[15] = mk(3,  9,  0, 0, 16'h0000, 0, 0,  16'h0000, 16'h0099, 1, 0, 16'h000C);

    rst = 1'b1; ra_addr = 0; rb_addr = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    issue_en = 0; issue_addr = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_busy = '0;
    #2;
    chk("reset_bv_byp", a_bv, 16'h0000);
    chk("reset_bv_nob", n_bv, 16'h0000);
    chk("reset_ra_byp", a_ra, 16'h0000);
    #10 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      ra_addr = tbl[i].ra; rb_addr = tbl[i].rb;
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      issue_en = tbl[i].ie; issue_addr = tbl[i].ia;
      e.a_ra = tbl[i].e_ra; e.a_rb = tbl[i].e_rb;
      e.a_rab = tbl[i].e_rab; e.a_rbb = tbl[i].e_rbb; e.a_bv = tbl[i].e_bv;
      e.n_ra  = (tbl[i].ra == 0) ? 16'h0 : m_regs[tbl[i].ra];
      e.n_rb  = (tbl[i].rb == 0) ? 16'h0 : m_regs[tbl[i].rb];
      e.n_rab = m_busy[tbl[i].ra];
      e.n_rbb = m_busy[tbl[i].rb];
      e.n_bv  = m_busy;
      exp_q.push_back(e);

      @(negedge clk);
      g = exp_q.pop_front();
      chk($sformatf("v%0d_ra_byp", i), a_ra, g.a_ra);
      chk($sformatf("v%0d_rb_byp", i), a_rb, g.a_rb);
      chk($sformatf("v%0d_rab_byp", i), 16'(a_rab), 16'(g.a_rab));
      chk($sformatf("v%0d_rbb_byp", i), 16'(a_rbb), 16'(g.a_rbb));
      chk($sformatf("v%0d_bv_byp", i), a_bv, g.a_bv);
      chk($sformatf("v%0d_ra_nob", i), n_ra, g.n_ra);
      chk($sformatf("v%0d_rb_nob", i), n_rb, g.n_rb);
      chk($sformatf("v%0d_rab_nob", i), 16'(n_rab), 16'(g.n_rab));
      chk($sformatf("v%0d_rbb_nob", i), 16'(n_rbb), 16'(g.n_rbb));
      chk($sformatf("v%0d_bv_nob", i), n_bv, g.n_bv);

      if (tbl[i].we && tbl[i].wa != 0) begin
        m_regs[tbl[i].wa] = tbl[i].wd;
        m_busy[tbl[i].wa] = 1'b0;
      end
      if (tbl[i].ie && tbl[i].ia != 0) m_busy[tbl[i].ia] = 1'b1;
    end

    // Write r3 then reset asynchronously between edges.
    @(posedge clk); #1;
    wr_en = 1; wr_addr = 3; wr_data = 16'h00A5; issue_en = 0; ra_addr = 3; rb_addr = 3;
    @(negedge clk);
    chk("r3_pre_byp", a_ra, 16'h00A5);
    chk("r3_pre_nob", n_ra, 16'h0000);
    @(posedge clk); #1;
    wr_en = 0;
    chk("r3_post_byp", a_ra, 16'h00A5);
    chk("r3_post_nob", n_ra, 16'h00A5);
    chk("bv_before_rst", a_bv, 16'h0004);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ra_byp", a_ra, 16'h0000);
    chk("rst_async_ra_nob", n_ra, 16'h0000);
    chk("rst_async_bv_byp", a_bv, 16'h0000);
    chk("rst_async_bv_nob", n_bv, 16'h0000);

    wr_en = 1; wr_addr = 3; wr_data = 16'h0011; issue_en = 1; issue_addr = 6;
    @(negedge clk);
    chk("rst_no_bypass_ra", a_ra, 16'h0000);
    @(posedge clk); #1;
    chk("rst_hold_ra", a_ra, 16'h0000);
    chk("rst_hold_bv", a_bv, 16'h0000);
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    wr_en = 0; issue_en = 0;
    chk("post_rst_ra_byp", a_ra, 16'h0011);
    chk("post_rst_ra_nob", n_ra, 16'h0011);
    chk("post_rst_bv_byp", a_bv, 16'h0040);
    chk("post_rst_bv_nob", n_bv, 16'h0040);
    ra_addr = 2; #1;
    chk("post_rst_r2_cleared", a_ra, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
